up_down_counter_cfg: RTL and testbench

Parametrised up/down counter; next generation of the team's 3-bit up/down counter. Adds configurable width and modulus, a wrap or saturate mode, count enable, synchronous parallel load, boundary pulses and sticky overflow/underflow flags. Used as a general event/position counter in datapath and control blocks.

---
 rtl/up_down_counter_cfg.sv | 79 +++++++
 tb/tb_up_down_counter_cfg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_cfg.sv
// Parametrised up/down counter with wrap or saturate at configurable bounds,
// parallel load with clamping, boundary pulse and sticky over/underflow flags.
module up_down_counter_cfg #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             load_clamped,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic             load_over;
  logic [WIDTH-1:0] load_target;
  logic             up_event;
  logic             down_event;

  // Bounds are tested before stepping, so count+1 can never overflow even
  // when MAX_VAL is the all-ones value.
  always_comb begin
    load_over   = (load_value > MAX_VAL);
    load_target = load_over ? MAX_VAL : load_value;
    up_event    = !load && en &&  up_down && (count == MAX_VAL);
    down_event  = !load && en && !up_down && (count == ZERO);
  end

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == ZERO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= ZERO;
      tc           <= 1'b0;
      load_clamped <= 1'b0;
      ovf          <= 1'b0;
      unf          <= 1'b0;
    end else begin
      tc           <= up_event || down_event;
      load_clamped <= load && load_over;

      // A boundary event in the same cycle as clr_flags leaves its flag set.
      ovf <= up_event   || (ovf && !clr_flags);
      unf <= down_event || (unf && !clr_flags);

      if (load) begin
        count <= load_target;
      end else if (en) begin
        if (up_down) begin
          if (count != MAX_VAL) begin
            count <= count + ONE;
          end else if (!SATURATE) begin
            count <= ZERO;
          end
        end else begin
          if (count != ZERO) begin
            count <= count - ONE;
          end else if (!SATURATE) begin
            count <= MAX_VAL;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_up_down_counter_cfg.sv
// Directed bench for up_down_counter_cfg: wrap, saturate and full-range instances
// share control inputs; each task checks one feature against hand-computed values.
module tb_up_down_counter_cfg;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       up_down;
  logic       load;
  logic       clr_flags;
  logic [3:0] lv4;
  logic [7:0] lv8;

  logic [3:0] a_count, b_count;
  logic [7:0] c_count;
  logic a_max, a_min, a_tc, a_lc, a_ovf, a_unf;
  logic b_max, b_min, b_tc, b_lc, b_ovf, b_unf;
  logic c_max, c_min, c_tc, c_lc, c_ovf, c_unf;

  int checks;
  int errors;

  up_down_counter_cfg #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down), .load(load),
    .load_value(lv4), .clr_flags(clr_flags), .count(a_count), .at_max(a_max),
    .at_min(a_min), .tc(a_tc), .load_clamped(a_lc), .ovf(a_ovf), .unf(a_unf)
  );

  up_down_counter_cfg #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down), .load(load),
    .load_value(lv4), .clr_flags(clr_flags), .count(b_count), .at_max(b_max),
    .at_min(b_min), .tc(b_tc), .load_clamped(b_lc), .ovf(b_ovf), .unf(b_unf)
  );

  up_down_counter_cfg #(.WIDTH(8), .MAX_VAL(8'd255), .SATURATE(1'b0)) dut_full (
    .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down), .load(load),
    .load_value(lv8), .clr_flags(clr_flags), .count(c_count), .at_max(c_max),
    .at_min(c_min), .tc(c_tc), .load_clamped(c_lc), .ovf(c_ovf), .unf(c_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; load = 1'b0; clr_flags = 1'b0; up_down = 1'b1;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    en = 1'b1; up_down = 1'b1;
    repeat (5) step();
    checks++;
    if (a_count !== 4'd5) begin
      errors++; $display("[TB] FAIL reset_precount actual=%0d expected=5", a_count);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if ({a_count, a_tc, a_lc, a_ovf, a_unf} !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_async count=%0d tc=%b lc=%b ovf=%b unf=%b expected all 0",
                         a_count, a_tc, a_lc, a_ovf, a_unf);
    end
    checks++;
    if ({a_min, a_max} !== 2'b10) begin
      errors++; $display("[TB] FAIL reset_bounds at_min=%b at_max=%b expected 1 0", a_min, a_max);
    end
    en = 1'b0;
    reset_n = 1'b1;
    step();
    checks++;
    if (a_count !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_hold actual=%0d expected=0", a_count);
    end
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_cnt;
    do_reset();
    en = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_cnt = 4'((i + 1) % 10);
      checks++;
      if (a_count !== exp_cnt || a_tc !== (i == 9)) begin
        errors++; $display("[TB] FAIL wrap_up_%0d count=%0d tc=%b expected count=%0d tc=%b",
                           i, a_count, a_tc, exp_cnt, (i == 9));
      end
      checks++;
      if (a_max !== (exp_cnt == 4'd9)) begin
        errors++; $display("[TB] FAIL wrap_up_at_max_%0d actual=%b expected=%b",
                           i, a_max, (exp_cnt == 4'd9));
      end
    end
    checks++;
    if (a_ovf !== 1'b1 || a_unf !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_up_flags ovf=%b unf=%b expected 1 0", a_ovf, a_unf);
    end
  endtask

  task automatic test_wrap_down_saturate();
    do_reset();
    en = 1'b1; up_down = 1'b0;
    step();
    checks++;
    if (a_count !== 4'd9 || a_tc !== 1'b1 || a_unf !== 1'b1 || a_ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_down count=%0d tc=%b unf=%b ovf=%b expected 9 1 1 0",
                         a_count, a_tc, a_unf, a_ovf);
    end
    checks++;
    if (b_count !== 4'd0 || b_tc !== 1'b1 || b_unf !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_down count=%0d tc=%b unf=%b expected 0 1 1",
                         b_count, b_tc, b_unf);
    end
    load = 1'b1; lv4 = 4'd9;
    step();
    checks++;
    if (b_count !== 4'd9 || b_tc !== 1'b0 || b_lc !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_load count=%0d tc=%b lc=%b expected 9 0 0",
                         b_count, b_tc, b_lc);
    end
    load = 1'b0; up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (b_count !== 4'd9 || b_tc !== 1'b1 || b_ovf !== 1'b1 || b_max !== 1'b1) begin
        errors++; $display("[TB] FAIL sat_up_%0d count=%0d tc=%b ovf=%b at_max=%b expected 9 1 1 1",
                           i, b_count, b_tc, b_ovf, b_max);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if (b_tc !== 1'b0 || b_count !== 4'd9) begin
      errors++; $display("[TB] FAIL sat_idle count=%0d tc=%b expected 9 0", b_count, b_tc);
    end
  endtask

  task automatic test_load();
    do_reset();
    en = 1'b1; up_down = 1'b1; load = 1'b1; lv4 = 4'd13;
    step();
    checks++;
    if (a_count !== 4'd9 || a_lc !== 1'b1 || a_tc !== 1'b0) begin
      errors++; $display("[TB] FAIL load_clamp count=%0d lc=%b tc=%b expected 9 1 0",
                         a_count, a_lc, a_tc);
    end
    lv4 = 4'd4;
    step();
    checks++;
    if (a_count !== 4'd4 || a_lc !== 1'b0) begin
      errors++; $display("[TB] FAIL load_plain count=%0d lc=%b expected 4 0", a_count, a_lc);
    end
    load = 1'b0; en = 1'b0;
    step();
    checks++;
    if (a_count !== 4'd4 || a_lc !== 1'b0 || a_tc !== 1'b0) begin
      errors++; $display("[TB] FAIL load_hold count=%0d lc=%b tc=%b expected 4 0 0",
                         a_count, a_lc, a_tc);
    end
  endtask

  task automatic test_flag_clear();
    do_reset();
    load = 1'b1; lv4 = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up_down = 1'b1;
    step();
    checks++;
    if (a_count !== 4'd0 || a_ovf !== 1'b1 || a_tc !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_setup count=%0d ovf=%b tc=%b expected 0 1 1",
                         a_count, a_ovf, a_tc);
    end
    up_down = 1'b0; clr_flags = 1'b1;
    step();
    checks++;
    if (a_count !== 4'd9 || a_ovf !== 1'b0 || a_unf !== 1'b1 || a_tc !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_race count=%0d ovf=%b unf=%b tc=%b expected 9 0 1 1",
                         a_count, a_ovf, a_unf, a_tc);
    end
    en = 1'b0;
    step();
    checks++;
    if (a_ovf !== 1'b0 || a_unf !== 1'b0 || a_tc !== 1'b0 || a_count !== 4'd9) begin
      errors++; $display("[TB] FAIL clr_plain count=%0d ovf=%b unf=%b tc=%b expected 9 0 0 0",
                         a_count, a_ovf, a_unf, a_tc);
    end
    clr_flags = 1'b0;
  endtask

  task automatic test_full_range();
    do_reset();
    load = 1'b1; lv8 = 8'd254;
    step();
    checks++;
    if (c_count !== 8'd254 || c_max !== 1'b0 || c_lc !== 1'b0) begin
      errors++; $display("[TB] FAIL full_load count=%0d at_max=%b lc=%b expected 254 0 0",
                         c_count, c_max, c_lc);
    end
    load = 1'b0; en = 1'b1; up_down = 1'b1;
    step();
    checks++;
    if (c_count !== 8'd255 || c_max !== 1'b1 || c_tc !== 1'b0 || c_ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL full_top count=%0d at_max=%b tc=%b ovf=%b expected 255 1 0 0",
                         c_count, c_max, c_tc, c_ovf);
    end
    step();
    checks++;
    if (c_count !== 8'd0 || c_max !== 1'b0 || c_min !== 1'b1 || c_tc !== 1'b1 || c_ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL full_wrap count=%0d at_max=%b at_min=%b tc=%b ovf=%b expected 0 0 1 1 1",
                         c_count, c_max, c_min, c_tc, c_ovf);
    end
    en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0; en = 1'b0; up_down = 1'b1; load = 1'b0; clr_flags = 1'b0;
    lv4 = 4'd0; lv8 = 8'd0;
    #12;
    $display("[TB] starting directed tests");
    test_reset();
    test_wrap_up();
    test_wrap_down_saturate();
    test_load();
    test_flag_clear();
    test_full_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
